// File: rtl/de1_io_pkg.sv
// Board-level constants shared by the DE1 input conditioning logic.
package de1_io_pkg;

    localparam int   DEBOUNCE_5MS_50MHZ = 250000;
    localparam int   N_KEY_DE1          = 3;
    localparam int   N_SW_DE1           = 10;
    localparam logic KEY_RELEASED       = 1'b1;
    localparam logic SW_RESET_LEVEL     = 1'b0;

endpackage

// File: rtl/de1_input_conditioner_if.sv
// Pin-side and PIO-side signals of the DE1 input conditioner.
// master = the board/top level (drives raw pins), slave = the conditioner.
interface de1_input_conditioner_if #(
    parameter int N_KEY = 3,
    parameter int N_SW  = 10
);

    logic [N_KEY-1:0] key_in;
    logic [N_SW-1:0]  sw_in;
    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_press;
    logic [N_KEY-1:0] key_release;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_change;

    modport master (
        output key_in,
        output sw_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  sw_level,
        input  sw_change
    );

    modport slave (
        input  key_in,
        input  sw_in,
        output key_level,
        output key_press,
        output key_release,
        output sw_level,
        output sw_change
    );

endinterface

// File: rtl/de1_input_conditioner_debounce_bit.sv
// One asynchronous pin: 2-flop synchroniser, stability counter, accepted level
// and registered single-cycle rise/fall strobes.
module debounce_bit
    import de1_io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic sync1_q;
    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic sync2_q;

    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            level_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any cycle where the synchronised pin agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/de1_input_conditioner.sv
// Conditions DE1 KEY[3:1] (active-low) and SW[9:0] for the Nios II PIOs:
// clean debounced levels plus single-cycle press/release/change strobes.
module de1_input_conditioner
    import de1_io_pkg::*;
#(
    parameter int N_KEY           = N_KEY_DE1,
    parameter int N_SW            = N_SW_DE1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ
) (
    input  logic                    clk,
    input  logic                    reset,
    de1_input_conditioner_if.slave  io
);

    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        // Keys are active-low, so a press is the debounced falling edge.
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (KEY_RELEASED)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .d_i     (io.key_in[i]),
            .level_o (io.key_level[i]),
            .rise_o  (io.key_release[i]),
            .fall_o  (io.key_press[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        logic rise;
        logic fall;

        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (SW_RESET_LEVEL)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .d_i     (io.sw_in[i]),
            .level_o (io.sw_level[i]),
            .rise_o  (rise),
            .fall_o  (fall)
        );

        assign io.sw_change[i] = rise | fall;
    end

endmodule

// File: tb/tb_de1_input_conditioner.sv
// Bench for de1_input_conditioner with a short debounce window; outputs are
// compared every cycle against a sliding-window model of the pin history.
module tb_de1_input_conditioner;

    localparam int D  = 8;
    localparam int HL = D + 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    de1_input_conditioner_if #(.N_KEY(3), .N_SW(10)) io ();

    de1_input_conditioner #(
        .N_KEY           (3),
        .N_SW            (10),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a level flips when the D most recent synchronised samples
    // (pin values seen 2..D+1 edges ago) all disagree with it.
    logic [2:0] m_key_level, m_press, m_release;
    logic [9:0] m_sw_level, m_change;
    logic [2:0] kh [HL];
    logic [9:0] sh [HL];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key_level = 3'b111;
        m_press     = '0;
        m_release   = '0;
        m_sw_level  = '0;
        m_change    = '0;
        for (int i = 0; i < HL; i++) begin
            kh[i] = 3'b111;
            sh[i] = '0;
        end
    endtask

    task automatic model_edge();
        logic stable;
        m_press   = '0;
        m_release = '0;
        m_change  = '0;
        for (int b = 0; b < 3; b++) begin
            stable = 1'b1;
            for (int i = 1; i <= D; i++)
                if (kh[i][b] == m_key_level[b]) stable = 1'b0;
            if (stable) begin
                m_press[b]     = m_key_level[b];
                m_release[b]   = ~m_key_level[b];
                m_key_level[b] = ~m_key_level[b];
            end
        end
        for (int b = 0; b < 10; b++) begin
            stable = 1'b1;
            for (int i = 1; i <= D; i++)
                if (sh[i][b] == m_sw_level[b]) stable = 1'b0;
            if (stable) begin
                m_change[b]   = 1'b1;
                m_sw_level[b] = ~m_sw_level[b];
            end
        end
        for (int i = HL - 1; i > 0; i--) begin
            kh[i] = kh[i-1];
            sh[i] = sh[i-1];
        end
        kh[0] = io.key_in;
        sh[0] = io.sw_in;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".key_level"},   32'(io.key_level),   32'(m_key_level));
        check({tag, ".key_press"},   32'(io.key_press),   32'(m_press));
        check({tag, ".key_release"}, 32'(io.key_release), 32'(m_release));
        check({tag, ".sw_level"},    32'(io.sw_level),    32'(m_sw_level));
        check({tag, ".sw_change"},   32'(io.sw_change),   32'(m_change));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_all("cycle");
    endtask

    // Steps until the chosen level bit reaches val; returns 0 on timeout.
    task automatic wait_level(input bit is_sw, input int b, input logic val, output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if ((is_sw ? io.sw_level[b] : io.key_level[b]) === val) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_immediate");
        repeat (3) step();
        reset = 1'b0;
    endtask

    int lat;

    initial begin
        reset     = 1'b1;
        io.key_in = 3'b111;
        io.sw_in  = '0;
        #1;
        model_reset();
        check_all("reset_state");
        repeat (3) step();
        reset = 1'b0;

        // Idle pins: nothing moves.
        repeat (100) step();

        // Clean press and release of key 1.
        io.key_in[1] = 1'b0;
        wait_level(1'b0, 1, 1'b0, lat);
        check("key1_press_latency", 32'(lat), 32'd10);
        check("key1_press_strobe", 32'(io.key_press[1]), 32'd1);
        step();
        io.key_in[1] = 1'b1;
        wait_level(1'b0, 1, 1'b1, lat);
        check("key1_release_latency", 32'(lat), 32'd10);
        check("key1_release_strobe", 32'(io.key_release[1]), 32'd1);
        step();

        // Key 2 bounces with 3-cycle segments, then settles pressed.
        for (int seg = 0; seg < 14; seg++) begin
            io.key_in[2] = seg[0];
            repeat (3) step();
        end
        check("key2_no_early_press", 32'(io.key_level[2]), 32'd1);
        io.key_in[2] = 1'b0;
        wait_level(1'b0, 2, 1'b0, lat);
        check("key2_bounce_latency", 32'(lat), 32'd10);
        check("key2_bounce_strobe", 32'(io.key_press[2]), 32'd1);
        io.key_in[2] = 1'b1;
        repeat (12) step();

        // Switch 9: 7-cycle pulse rejected, 8-cycle pulse accepted.
        io.sw_in[9] = 1'b1;
        repeat (7) step();
        io.sw_in[9] = 1'b0;
        repeat (12) step();
        check("sw9_short_pulse", 32'(io.sw_level[9]), 32'd0);
        io.sw_in[9] = 1'b1;
        repeat (8) step();
        io.sw_in[9] = 1'b0;
        repeat (2) step();
        check("sw9_long_pulse_level", 32'(io.sw_level[9]), 32'd1);
        check("sw9_long_pulse_strobe", 32'(io.sw_change[9]), 32'd1);
        wait_level(1'b1, 9, 1'b0, lat);
        check("sw9_fall_after_rise", 32'(lat), 32'd8);
        repeat (4) step();

        // Reset in the middle of a pending switch edge, pin held high.
        io.sw_in[0] = 1'b1;
        repeat (7) step();
        do_reset();
        check("sw0_reset_no_strobe", 32'(io.sw_change), 32'd0);
        wait_level(1'b1, 0, 1'b1, lat);
        check("sw0_redebounce_latency", 32'(lat), 32'd10);
        check("sw0_redebounce_strobe", 32'(io.sw_change[0]), 32'd1);

        // Every pin changes at once: all 13 strobes coincide.
        io.sw_in = '0;
        repeat (12) step();
        io.key_in = 3'b000;
        io.sw_in  = 10'h3FF;
        repeat (9) step();
        check("all_no_early_strobe", 32'({io.key_press, io.sw_change}), 32'd0);
        step();
        check("all_press_strobes", 32'(io.key_press), 32'h7);
        check("all_sw_strobes", 32'(io.sw_change), 32'h3FF);
        step();
        check("all_strobes_one_wide", 32'({io.key_press, io.sw_change}), 32'd0);

        // Random pin activity with mixed hold times around the window length.
        repeat (80) begin
            if ($urandom_range(0, 2) == 0) io.key_in = 3'($urandom_range(0, 7));
            io.sw_in = io.sw_in ^ 10'(1 << $urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) io.sw_in = 10'($urandom_range(0, 1023));
            repeat ($urandom_range(1, 12)) step();
        end
        if ($urandom_range(0, 9) == 0) do_reset();
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
